hb_decim_fir: RTL and testbench



---
 rtl/hb_decim_fir.sv | 112 +++++++++++
 tb/tb_hb_decim_fir.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_decim_fir.sv
// Complex (I/Q) 11-tap half-band low-pass FIR with decimate-by-2.
// Both rails share the same Q9 coefficients and a three-stage pipeline after the delay line.
module hb_decim_fir #(
    parameter int WIDTH = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic signed [WIDTH-1:0] i_inph_data,
    input  logic signed [WIDTH-1:0] i_quad_data,
    input  logic                    i_valid,
    output logic signed [WIDTH-1:0] o_inph_data,
    output logic signed [WIDTH-1:0] o_quad_data,
    output logic                    o_valid
);

    localparam int ACC_W = WIDTH + 11;
    localparam int TAPS  = 11;

    localparam logic signed [ACC_W-1:0] C_OUTER  = ACC_W'(3);
    localparam logic signed [ACC_W-1:0] C_INNER  = ACC_W'(-25);
    localparam logic signed [ACC_W-1:0] C_NEAR   = ACC_W'(150);
    localparam logic signed [ACC_W-1:0] ROUND    = ACC_W'(256);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Rail 0 is in-phase, rail 1 is quadrature; index 0 of the delay line is the newest sample.
    logic signed [WIDTH-1:0] dline [2][TAPS];
    logic signed [ACC_W-1:0] prod  [2][4];
    logic signed [ACC_W-1:0] acc   [2];
    logic                    phase;
    logic                    trig;
    logic                    valid_s1;
    logic                    valid_s2;

    function automatic logic signed [ACC_W-1:0] ext(input logic signed [WIDTH-1:0] x);
        return {{(ACC_W-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = (a + ROUND) >>> 9;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        return r[WIDTH-1:0];
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int r = 0; r < 2; r++) begin
                for (int k = 0; k < TAPS; k++) begin
                    dline[r][k] <= '0;
                end
            end
            phase <= 1'b0;
            trig  <= 1'b0;
        end else begin
            trig <= i_valid & phase;
            if (i_valid) begin
                phase       <= ~phase;
                dline[0][0] <= i_inph_data;
                dline[1][0] <= i_quad_data;
                for (int r = 0; r < 2; r++) begin
                    for (int k = 1; k < TAPS; k++) begin
                        dline[r][k] <= dline[r][k-1];
                    end
                end
            end
        end
    end

    // Symmetric taps are pre-added so only three multiplies per rail remain; the centre tap is a shift.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int r = 0; r < 2; r++) begin
                for (int p = 0; p < 4; p++) begin
                    prod[r][p] <= '0;
                end
                acc[r] <= '0;
            end
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
        end else begin
            valid_s1 <= trig;
            valid_s2 <= valid_s1;
            for (int r = 0; r < 2; r++) begin
                prod[r][0] <= C_OUTER * (ext(dline[r][0]) + ext(dline[r][10]));
                prod[r][1] <= C_INNER * (ext(dline[r][2]) + ext(dline[r][8]));
                prod[r][2] <= C_NEAR  * (ext(dline[r][4]) + ext(dline[r][6]));
                prod[r][3] <= ext(dline[r][5]) <<< 8;
                acc[r]     <= prod[r][0] + prod[r][1] + prod[r][2] + prod[r][3];
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_inph_data <= '0;
            o_quad_data <= '0;
        end else begin
            o_valid <= valid_s2;
            if (valid_s2) begin
                o_inph_data <= round_sat(acc[0]);
                o_quad_data <= round_sat(acc[1]);
            end
        end
    end

endmodule

// File: tb/tb_hb_decim_fir.sv
// Scoreboard bench for hb_decim_fir: a direct-form reference model predicts every output and its cycle.
module tb_hb_decim_fir;

    localparam int WIDTH = 16;

    logic                    i_clock = 1'b0;
    logic                    i_reset = 1'b1;
    logic signed [WIDTH-1:0] i_inph_data = '0;
    logic signed [WIDTH-1:0] i_quad_data = '0;
    logic                    i_valid = 1'b0;
    logic signed [WIDTH-1:0] o_inph_data;
    logic signed [WIDTH-1:0] o_quad_data;
    logic                    o_valid;

    hb_decim_fir #(.WIDTH(WIDTH)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_inph_data (i_inph_data),
        .i_quad_data (i_quad_data),
        .i_valid     (i_valid),
        .o_inph_data (o_inph_data),
        .o_quad_data (o_quad_data),
        .o_valid     (o_valid)
    );

    always #5 i_clock = ~i_clock;

    typedef struct { int cyc; int i; int q; } exp_t;
    typedef struct { int i; int q; } obs_t;

    exp_t sb[$];
    obs_t obs[$];
    int   coef[11] = '{3, 0, -25, 0, 150, 256, 150, 0, -25, 0, 3};
    int   hist_i[11];
    int   hist_q[11];
    bit   m_phase;
    int   cycle = 0;
    logic rst_q = 1'b0;
    int   last_i = 0;
    int   last_q = 0;
    int   n_asserts = 0;
    int   n_fails = 0;

    always @(posedge i_clock) begin
        cycle <= cycle + 1;
        rst_q <= i_reset;
    end

    task automatic check_output(input string tag, input logic signed [63:0] observed,
                                input logic signed [63:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int model_out(input int x[11]);
        longint a = 0;
        for (int k = 0; k < 11; k++) a += longint'(coef[k]) * longint'(x[k]);
        a = (a + 256) >>> 9;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return int'(a);
    endfunction

    task automatic apply_stimulus(input bit v, input int i, input int q);
        exp_t e;
        @(negedge i_clock);
        i_valid     = v;
        i_inph_data = WIDTH'(i);
        i_quad_data = WIDTH'(q);
        if (v) begin
            for (int k = 10; k > 0; k--) begin
                hist_i[k] = hist_i[k-1];
                hist_q[k] = hist_q[k-1];
            end
            hist_i[0] = i;
            hist_q[0] = q;
            if (m_phase) begin
                e.cyc = cycle + 4;
                e.i   = model_out(hist_i);
                e.q   = model_out(hist_q);
                sb.push_back(e);
            end
            m_phase = ~m_phase;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 0, 0);
    endtask

    // Reset lands on the next edge, so only predictions due after that edge are discarded.
    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        i_valid = 1'b0;
        while (sb.size() > 0 && sb[$].cyc > cycle) void'(sb.pop_back());
        for (int k = 0; k < 11; k++) begin
            hist_i[k] = 0;
            hist_q[k] = 0;
        end
        m_phase = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b0;
    endtask

    function automatic int obs_i(input int k);
        return (k < obs.size()) ? obs[k].i : 999999;
    endfunction

    function automatic int obs_q(input int k);
        return (k < obs.size()) ? obs[k].q : 999999;
    endfunction

    always @(negedge i_clock) begin
        exp_t e;
        obs_t o;
        if (cycle > 0) begin
            if (rst_q) begin
                check_output("reset_valid", o_valid, 0);
                check_output("reset_inph", o_inph_data, 0);
                check_output("reset_quad", o_quad_data, 0);
                last_i = 0;
                last_q = 0;
            end else if (o_valid === 1'b1) begin
                o.i = int'(o_inph_data);
                o.q = int'(o_quad_data);
                obs.push_back(o);
                if (sb.size() == 0) begin
                    check_output("spurious_valid", o_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("out_cycle", cycle, e.cyc);
                    check_output("out_inph", o_inph_data, e.i);
                    check_output("out_quad", o_quad_data, e.q);
                    last_i = e.i;
                    last_q = e.q;
                end
            end else begin
                check_output("idle_valid", o_valid, 0);
                check_output("hold_inph", o_inph_data, last_i);
                check_output("hold_quad", o_quad_data, last_q);
                if (sb.size() > 0 && sb[0].cyc < cycle) begin
                    check_output("missing_output", cycle, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int   imp1[7] = '{96, -800, 4800, 4800, -800, 96, 0};
        int   imp0[7] = '{0, 0, 8192, 0, 0, 0, 0};
        int   val;
        int   k;
        int   n_at_reset;
        real  pi = 3.14159265358979;
        real  mag;
        real  ang;
        real  prev_ang;
        real  d;

        repeat (3) @(negedge i_clock);
        do_reset();
        check_output("post_reset_valid", o_valid, 0);
        check_output("post_reset_inph", o_inph_data, 0);

        $display("[TB] idle after reset");
        obs.delete();
        idle(100);
        check_output("idle_outputs", obs.size(), 0);
        check_output("idle_inph", o_inph_data, 0);

        $display("[TB] DC input");
        do_reset();
        obs.delete();
        for (int n = 0; n < 40; n++) apply_stimulus(1'b1, 1000, -1000);
        idle(8);
        check_output("dc_count", obs.size(), 20);
        check_output("dc_first_inph", obs_i(0), 6);
        check_output("dc_first_quad", obs_q(0), -6);
        for (int n = 5; n < 20; n++) begin
            check_output("dc_settled_inph", obs_i(n), 1000);
            check_output("dc_settled_quad", obs_q(n), -1000);
        end
        check_output("dc_drain", sb.size(), 0);

        $display("[TB] impulse at input 1");
        do_reset();
        obs.delete();
        for (int n = 0; n < 14; n++) begin
            apply_stimulus(1'b1, (n == 1) ? 16384 : 0, 0);
            if (n % 3 == 2) idle(n % 4);
        end
        idle(8);
        for (int n = 0; n < 7; n++) begin
            check_output("imp1_inph", obs_i(n), imp1[n]);
            check_output("imp1_quad", obs_q(n), 0);
        end

        $display("[TB] impulse at input 0");
        do_reset();
        obs.delete();
        for (int n = 0; n < 14; n++) apply_stimulus(1'b1, (n == 0) ? 16384 : 0, 0);
        idle(8);
        for (int n = 0; n < 7; n++) check_output("imp0_inph", obs_i(n), imp0[n]);

        $display("[TB] saturation, positive on I and negative on Q");
        do_reset();
        obs.delete();
        for (int j = 0; j < 12; j++) begin
            k = 11 - j;
            val = (k > 10) ? 0 : (coef[k] > 0) ? 1 : (coef[k] < 0) ? -1 : 0;
            apply_stimulus(1'b1, (val > 0) ? 32767 : (val < 0) ? -32768 : 0,
                                 (val > 0) ? -32768 : (val < 0) ? 32767 : 0);
        end
        idle(8);
        check_output("sat_count", obs.size(), 6);
        check_output("sat_pos_inph", obs_i(5), 32767);
        check_output("sat_neg_quad", obs_q(5), -32768);
        check_output("sat_drain", sb.size(), 0);

        $display("[TB] tone and rate check");
        do_reset();
        obs.delete();
        for (int n = 0; n < 10000; n++) begin
            apply_stimulus(1'b1,
                $rtoi($floor(16384.0 * $cos(2.0 * pi * 0.001 * n) + 0.5)),
                $rtoi($floor(16384.0 * $sin(2.0 * pi * 0.001 * n) + 0.5)));
        end
        idle(5);
        check_output("tone_count", obs.size(), 5000);
        prev_ang = 0.0;
        for (int n = 10; n < 5000; n++) begin
            mag = $sqrt(real'(obs_i(n)) * obs_i(n) + real'(obs_q(n)) * obs_q(n));
            check_output("tone_mag", (mag >= 16320.0 && mag <= 16448.0), 1);
            ang = $atan2(real'(obs_q(n)), real'(obs_i(n))) * 180.0 / pi;
            if (n > 10) begin
                d = ang - prev_ang;
                if (d > 180.0) d -= 360.0;
                if (d <= -180.0) d += 360.0;
                check_output("tone_phase_step", (d > 0.70 && d < 0.74), 1);
            end
            prev_ang = ang;
        end
        for (int n = 10000; n < 10007; n++) begin
            apply_stimulus(1'b1,
                $rtoi($floor(16384.0 * $cos(2.0 * pi * 0.001 * n) + 0.5)),
                $rtoi($floor(16384.0 * $sin(2.0 * pi * 0.001 * n) + 0.5)));
        end
        do_reset();
        n_at_reset = obs.size();
        idle(20);
        check_output("tone_total", n_at_reset, 5002);
        check_output("no_valid_after_reset", obs.size(), n_at_reset);
        check_output("final_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
